// File: rtl/ain_debounce_pkg.sv
// rtl/ain_debounce_pkg.sv - shared state and code definitions for ain_debounce
package ain_debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } ain_db_state_t;

    localparam logic [1:0] AIN_NONE = 2'b00;
    localparam logic [1:0] AIN_01   = 2'b01;
    localparam logic [1:0] AIN_10   = 2'b10;
    localparam logic [1:0] AIN_11   = 2'b11;

    localparam logic [7:0] GLITCH_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == GLITCH_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ain_debounce_bit_sync.sv
// rtl/ain_debounce_bit_sync.sv - N-flop single-bit synchroniser, async active-low reset
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ain_debounce.sv
// rtl/ain_debounce.sv - 2-bit synchronise-and-debounce front end for the FSM ain input
// Optional glitch counter: AIN_DEBOUNCE_GLITCH_COUNT_EN
module ain_debounce
    import ain_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] raw_in,
    output logic [1:0] ain,
    output logic       ain_new,
`ifdef AIN_DEBOUNCE_GLITCH_COUNT_EN
    output logic [7:0] glitch_cnt,
`endif
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    ain_db_state_t state;
    logic [1:0]    cand;
    logic [CW-1:0] cnt;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b0 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (raw_in[0]),
        .q       (sync[0])
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b1 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (raw_in[1]),
        .q       (sync[1])
    );

    // The code is compared and released as a whole, so ain never mixes old and new bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_STABLE;
            cand    <= AIN_NONE;
            cnt     <= '0;
            ain     <= AIN_NONE;
            ain_new <= 1'b0;
        end else begin
            ain_new <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (sync != ain) begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (sync == ain) begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end else if (sync != cand) begin
                        cand <= sync;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        ain     <= cand;
                        ain_new <= 1'b1;
                        state   <= ST_STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_STABLE;
            endcase
        end
    end

    assign busy = (state == ST_SETTLE);

`ifdef AIN_DEBOUNCE_GLITCH_COUNT_EN
    logic reject;

    // Mirrors settle priorities 1 and 2: a reverted or replaced candidate.
    assign reject = (state == ST_SETTLE) && ((sync == ain) || (sync != cand));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= 8'd0;
        end else if (reject) begin
            glitch_cnt <= sat_inc8(glitch_cnt);
        end
    end
`endif

endmodule

// File: doc/ain_debounce.md
# ain_debounce

Input conditioner that sits directly upstream of the two-bit sequence-detector FSM and drives its `ain` input. It synchronises two raw, asynchronous sensor/switch lines into `clk` and debounces them as a single 2-bit code. A new code is released only after it has been stable for a programmable number of cycles. Transient intermediate codes, such as a momentary 01 while 00 moves to 11, therefore never reach the downstream FSM, which would otherwise treat them as distinct states.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop depth per bit, legal range 2–4.
- `DEBOUNCE_CYCLES`, default 8: consecutive cycles a candidate code must hold before release, legal range 1–65535.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low. It asserts immediately and releases on a `clk` edge.
- `raw_in`  in  2  unsynchronised input lines; bit 1 is the high bit of the code.
- `ain`  out  2  debounced code, registered, feeds the FSM `ain`.
- `ain_new`  out  1  one-cycle strobe, high in the cycle after `ain` changes value.
- `busy`  out  1  high while a candidate code is settling.
- `glitch_cnt`  out  8  saturating count of rejected candidates; present only with `AIN_DEBOUNCE_GLITCH_COUNT_EN`.

## Operation
- Each bit of `raw_in` passes through a `SYNC_STAGES`-deep flop chain. The resulting `sync` (2 bits) is the only path from `raw_in` to the rest of the block.
- Two-state FSM: STABLE and SETTLE. Registers:
  - `cand` (2 bits), the candidate code.
  - `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, the settle counter.
  - `ain`.
- STABLE:
  - If `sync == ain`: stay in STABLE.
  - Otherwise: `cand <= sync`, `cnt <= 0`, go to SETTLE.
- SETTLE, in priority order:
  1. If `sync == ain` (the input reverted): go to STABLE, `cnt <= 0`, count a glitch.
  2. Else if `sync != cand`: `cand <= sync`, `cnt <= 0`, stay in SETTLE, count a glitch.
  3. Else if `cnt == DEBOUNCE_CYCLES-1`: `ain <= cand`, pulse `ain_new`, go to STABLE.
  4. Otherwise: `cnt <= cnt + 1`.
- `busy` = (state == SETTLE), registered-state decode.
- `ain_new` is registered. It is high for exactly one cycle per `ain` update and never high in two consecutive cycles.
- A code change is released as a whole; `ain` never shows a mix of old and new bits.
- Reset mid-settle discards `cand`; no partial code is ever released.
- Reset values:
  - `ain` = 2'b00, `ain_new` = 0, `busy` = 0.
  - FSM in STABLE, `cnt` = 0, `cand` = 2'b00.
  - All synchroniser flops = 0.
  - `glitch_cnt` = 0.

## Timing
- Let raw_in change and hold from the edge E0 that first samples it. Then:
  - `sync` shows the new value after edge E0+`SYNC_STAGES`−1.
  - SETTLE is entered at E0+`SYNC_STAGES`.
  - `ain` updates at E0+`SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - `ain_new` is high during the cycle following that edge.
- With default parameters the latency is 10 cycles.
- A disturbance shorter than `DEBOUNCE_CYCLES` cycles at the `sync` output never changes `ain`.
- The downstream FSM samples `ain` directly; `ain` holds between updates.
- `DEBOUNCE_CYCLES` = 1 gives latency `SYNC_STAGES`+1, with the SETTLE-then-release sequence still enforced.

## Configuration
- `AIN_DEBOUNCE_GLITCH_COUNT_EN`
  - Defined: the 8-bit `glitch_cnt` port and register exist. The counter increments on each rejected candidate (SETTLE priorities 1 and 2) and saturates at 255. Reset clears it.
  - Undefined: the port and register are absent, and all other behaviour is identical.

## Structure
- Shared package `ain_debounce_pkg` holds:
  - the state enum `ain_db_state_t` {`ST_STABLE`, `ST_SETTLE`};
  - the code constants `AIN_NONE` = 2'b00, `AIN_01`, `AIN_10`, `AIN_11`, which are also used by the FSM bench.
- One sub-module, `bit_sync`: a parameterised N-flop synchroniser with async active-low reset, instantiated twice.

## Test plan
- Reset release with `raw_in` = 00 held: `ain` = 00, `ain_new` and `busy` stay 0 for 50 cycles.
- `raw_in` 00→11 held: `ain` = 11 exactly 10 cycles after the first sampling edge; `ain_new` is high for 1 cycle; `busy` is high for 8 cycles.
- Glitch on `raw_in`, 00→01 for 5 cycles then back to 00: `ain` stays 00 and `glitch_cnt` = 1 (macro on).
- Skewed transition: 00→01, then 2 cycles later 01→11, held: `ain` goes directly 00→11 and never shows 01; `glitch_cnt` = 1.
- `reset_n` asserted 4 cycles into SETTLE for code 10:
  - all outputs go to reset values immediately, asynchronously;
  - after release with `raw_in` still 10, `ain` = 10 exactly 10 cycles later.
- Macro on: 300 alternating short glitches give `glitch_cnt` = 255, saturated.
